// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: source encoding, null tag
// and the round-robin pick used when both result queues hold entries.
package cdb_arbiter_pkg;

    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_LSB = 1'b1;

    localparam int NULL_TAG = 0;

    // Source that wins this cycle; only meaningful when at least one queue is non-empty.
    function automatic logic rr_pick(input logic alu_ready, input logic lsb_ready,
                                     input logic last_grant);
        if (alu_ready && (!lsb_ready || last_grant == CDB_SRC_LSB))
            return CDB_SRC_ALU;
        return CDB_SRC_LSB;
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Small circular result queue with flush; head entry is read combinationally so a
// grant can register it onto the bus in the same cycle it is popped.
module cdb_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[head_reg];

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[tail_reg] <= push_data;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push)
                tail_reg <= tail_reg + 1'b1;
            if (do_pop)
                head_reg <= head_reg + 1'b1;
            if (do_push && !do_pop)
                count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push)
                count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered common data bus between the ALU and
// the load/store buffer, with a per-source result queue and rollback flush.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rollback_in,
    input  logic                  alu_valid_in,
    output logic                  alu_ready_out,
    input  logic [WORD_WIDTH-1:0] alu_result_in,
    input  logic [WORD_WIDTH-1:0] alu_new_pc_in,
    input  logic [TAG_WIDTH-1:0]  alu_dest_tag_in,
    input  logic                  lsb_valid_in,
    output logic                  lsb_ready_out,
    input  logic [WORD_WIDTH-1:0] lsb_result_in,
    input  logic [TAG_WIDTH-1:0]  lsb_dest_tag_in,
    output logic                  cdb_valid_out,
    output logic                  cdb_src_out,
    output logic [WORD_WIDTH-1:0] cdb_result_out,
    output logic [WORD_WIDTH-1:0] cdb_new_pc_out,
    output logic [TAG_WIDTH-1:0]  cdb_dest_tag_out
);

    localparam int ALU_W = 2 * WORD_WIDTH + TAG_WIDTH;
    localparam int LSB_W = WORD_WIDTH + TAG_WIDTH;

    logic             alu_full, alu_empty, lsb_full, lsb_empty;
    logic             alu_push, lsb_push, alu_pop, lsb_pop;
    logic             any_grant, grant_src;
    logic [ALU_W-1:0] alu_head;
    logic [LSB_W-1:0] lsb_head;

    logic                  valid_reg;
    logic                  src_reg;
    logic [WORD_WIDTH-1:0] result_reg;
    logic [WORD_WIDTH-1:0] new_pc_reg;
    logic [TAG_WIDTH-1:0]  tag_reg;
    logic                  last_grant_reg;

    assign alu_ready_out = !alu_full;
    assign lsb_ready_out = !lsb_full;

    // Null-tag results complete the handshake but are never queued.
    assign alu_push = alu_valid_in && !alu_full && !rollback_in
                      && (alu_dest_tag_in != TAG_WIDTH'(NULL_TAG));
    assign lsb_push = lsb_valid_in && !lsb_full && !rollback_in
                      && (lsb_dest_tag_in != TAG_WIDTH'(NULL_TAG));

    assign any_grant = !alu_empty || !lsb_empty;
    assign grant_src = rr_pick(!alu_empty, !lsb_empty, last_grant_reg);
    assign alu_pop   = any_grant && (grant_src == CDB_SRC_ALU) && !rollback_in;
    assign lsb_pop   = any_grant && (grant_src == CDB_SRC_LSB) && !rollback_in;

    cdb_result_fifo #(.WIDTH(ALU_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (rollback_in),
        .push      (alu_push),
        .pop       (alu_pop),
        .push_data ({alu_result_in, alu_new_pc_in, alu_dest_tag_in}),
        .head_data (alu_head),
        .full      (alu_full),
        .empty     (alu_empty)
    );

    cdb_result_fifo #(.WIDTH(LSB_W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (rollback_in),
        .push      (lsb_push),
        .pop       (lsb_pop),
        .push_data ({lsb_result_in, lsb_dest_tag_in}),
        .head_data (lsb_head),
        .full      (lsb_full),
        .empty     (lsb_empty)
    );

    // Rollback only kills the pulse; data outputs keep their last broadcast.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg      <= 1'b0;
            src_reg        <= 1'b0;
            result_reg     <= '0;
            new_pc_reg     <= '0;
            tag_reg        <= '0;
            last_grant_reg <= CDB_SRC_LSB;
        end else if (rollback_in) begin
            valid_reg      <= 1'b0;
            last_grant_reg <= CDB_SRC_LSB;
        end else if (any_grant) begin
            valid_reg      <= 1'b1;
            src_reg        <= grant_src;
            last_grant_reg <= grant_src;
            if (grant_src == CDB_SRC_ALU) begin
                result_reg <= alu_head[ALU_W-1 -: WORD_WIDTH];
                new_pc_reg <= alu_head[TAG_WIDTH +: WORD_WIDTH];
                tag_reg    <= alu_head[TAG_WIDTH-1:0];
            end else begin
                result_reg <= lsb_head[LSB_W-1 -: WORD_WIDTH];
                new_pc_reg <= '0;
                tag_reg    <= lsb_head[TAG_WIDTH-1:0];
            end
        end else begin
            valid_reg <= 1'b0;
        end
    end

    assign cdb_valid_out    = valid_reg;
    assign cdb_src_out      = src_reg;
    assign cdb_result_out   = result_reg;
    assign cdb_new_pc_out   = new_pc_reg;
    assign cdb_dest_tag_out = tag_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: queue-based reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_cdb_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        rollback_in;
    logic        alu_valid_in;
    logic        alu_ready_out;
    logic [31:0] alu_result_in;
    logic [31:0] alu_new_pc_in;
    logic [3:0]  alu_dest_tag_in;
    logic        lsb_valid_in;
    logic        lsb_ready_out;
    logic [31:0] lsb_result_in;
    logic [3:0]  lsb_dest_tag_in;
    logic        cdb_valid_out;
    logic        cdb_src_out;
    logic [31:0] cdb_result_out;
    logic [31:0] cdb_new_pc_out;
    logic [3:0]  cdb_dest_tag_out;

    cdb_arbiter #(.WORD_WIDTH(32), .TAG_WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .rollback_in      (rollback_in),
        .alu_valid_in     (alu_valid_in),
        .alu_ready_out    (alu_ready_out),
        .alu_result_in    (alu_result_in),
        .alu_new_pc_in    (alu_new_pc_in),
        .alu_dest_tag_in  (alu_dest_tag_in),
        .lsb_valid_in     (lsb_valid_in),
        .lsb_ready_out    (lsb_ready_out),
        .lsb_result_in    (lsb_result_in),
        .lsb_dest_tag_in  (lsb_dest_tag_in),
        .cdb_valid_out    (cdb_valid_out),
        .cdb_src_out      (cdb_src_out),
        .cdb_result_out   (cdb_result_out),
        .cdb_new_pc_out   (cdb_new_pc_out),
        .cdb_dest_tag_out (cdb_dest_tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] result;
        logic [31:0] new_pc;
        logic [3:0]  tag;
    } ent_t;

    ent_t        aq[$];
    ent_t        lq[$];
    logic        m_valid, m_src, m_last;
    logic [31:0] m_result, m_new_pc;
    logic [3:0]  m_tag;
    logic        log_src[$];
    logic [3:0]  log_tag[$];

    always @(posedge clk) begin
        ent_t e;
        bit   a_rdy, l_rdy;
        if (rst) begin
            aq.delete(); lq.delete();
            m_valid = 0; m_src = 0; m_result = 0; m_new_pc = 0; m_tag = 0; m_last = 1;
        end else if (rollback_in) begin
            aq.delete(); lq.delete();
            m_valid = 0; m_last = 1;
        end else begin
            a_rdy = (aq.size() != DEPTH);
            l_rdy = (lq.size() != DEPTH);
            if (aq.size() > 0 && (lq.size() == 0 || m_last == 1'b1)) begin
                e = aq.pop_front();
                m_valid = 1; m_src = 0; m_result = e.result; m_new_pc = e.new_pc; m_tag = e.tag;
                m_last = 0;
            end else if (lq.size() > 0) begin
                e = lq.pop_front();
                m_valid = 1; m_src = 1; m_result = e.result; m_new_pc = 0; m_tag = e.tag;
                m_last = 1;
            end else begin
                m_valid = 0;
            end
            if (m_valid) begin
                log_src.push_back(m_src);
                log_tag.push_back(m_tag);
            end
            if (alu_valid_in && a_rdy && alu_dest_tag_in != 0) begin
                e.result = alu_result_in; e.new_pc = alu_new_pc_in; e.tag = alu_dest_tag_in;
                aq.push_back(e);
            end
            if (lsb_valid_in && l_rdy && lsb_dest_tag_in != 0) begin
                e.result = lsb_result_in; e.new_pc = 0; e.tag = lsb_dest_tag_in;
                lq.push_back(e);
            end
        end
    end

    // Per-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_valid",  32'(cdb_valid_out),    32'(m_valid));
            check("cyc_src",    32'(cdb_src_out),      32'(m_src));
            check("cyc_result", cdb_result_out,        m_result);
            check("cyc_new_pc", cdb_new_pc_out,        m_new_pc);
            check("cyc_tag",    32'(cdb_dest_tag_out), 32'(m_tag));
            check("cyc_alu_rdy", 32'(alu_ready_out),   32'(aq.size() != DEPTH));
            check("cyc_lsb_rdy", 32'(lsb_ready_out),   32'(lq.size() != DEPTH));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_valid_in = 0; lsb_valid_in = 0; rollback_in = 0;
        alu_result_in = 0; alu_new_pc_in = 0; alu_dest_tag_in = 0;
        lsb_result_in = 0; lsb_dest_tag_in = 0;
    endtask

    task automatic do_rollback();
        rollback_in = 1;
        step();
        rollback_in = 0;
    endtask

    logic [3:0] exp_order [8] = '{4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd4, 4'd8};

    initial begin
        int ai, li, k;
        bit a_acc, l_acc, lsb_full_seen;

        idle_inputs();
        rst = 1;
        step();
        check_en = 1;
        step();
        rst = 0;
        check("reset_valid", 32'(cdb_valid_out), 32'd0);
        check("reset_tag", 32'(cdb_dest_tag_out), 32'd0);

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_valid", 32'(cdb_valid_out), 32'd0);
            check("idle_alu_rdy", 32'(alu_ready_out), 32'd1);
            check("idle_lsb_rdy", 32'(lsb_ready_out), 32'd1);
        end

        // Single ALU result: one edge to enqueue, one to broadcast.
        alu_valid_in = 1; alu_result_in = 32'h11; alu_new_pc_in = 32'h104; alu_dest_tag_in = 4'd3;
        step();
        idle_inputs();
        check("single_queued", 32'(cdb_valid_out), 32'd0);
        step();
        check("single_valid",  32'(cdb_valid_out), 32'd1);
        check("single_src",    32'(cdb_src_out), 32'd0);
        check("single_result", cdb_result_out, 32'h11);
        check("single_new_pc", cdb_new_pc_out, 32'h104);
        check("single_tag",    32'(cdb_dest_tag_out), 32'd3);
        step();
        check("single_after", 32'(cdb_valid_out), 32'd0);
        check("single_hold",   cdb_result_out, 32'h11);

        // Both sources at once from a fresh round-robin state.
        do_rollback();
        log_src.delete(); log_tag.delete();
        for (int i = 0; i < 4; i++) begin
            alu_valid_in = 1; alu_result_in = 32'h100 + i; alu_new_pc_in = 32'h1000 + 4 * i;
            alu_dest_tag_in = 4'(i + 1);
            lsb_valid_in = 1; lsb_result_in = 32'h200 + i; lsb_dest_tag_in = 4'(i + 5);
            check("both_alu_rdy", 32'(alu_ready_out), 32'd1);
            check("both_lsb_rdy", 32'(lsb_ready_out), 32'd1);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) step();
        check("both_count", log_tag.size(), 32'd8);
        for (int i = 0; i < 8 && i < log_tag.size(); i++)
            check("both_order", 32'(log_tag[i]), 32'(exp_order[i]));

        // Both saturated: LSB fills and its last entry must wait for a pop.
        do_rollback();
        log_src.delete(); log_tag.delete();
        ai = 0; li = 0; lsb_full_seen = 0;
        for (k = 0; k < 80 && (ai < 10 || li < 7); k++) begin
            alu_valid_in = (ai < 10);
            alu_result_in = 32'h300 + ai; alu_new_pc_in = 32'h3000 + ai; alu_dest_tag_in = 4'((ai % 7) + 1);
            lsb_valid_in = (li < 7);
            lsb_result_in = 32'h400 + li; lsb_dest_tag_in = 4'(li + 9);
            if (!lsb_ready_out) lsb_full_seen = 1;
            a_acc = alu_valid_in && alu_ready_out;
            l_acc = lsb_valid_in && lsb_ready_out;
            step();
            if (a_acc) ai++;
            if (l_acc) li++;
        end
        check("sat_done_in_budget", 32'(ai == 10 && li == 7), 32'd1);
        idle_inputs();
        for (int i = 0; i < 20; i++) step();
        check("sat_lsb_full_seen", 32'(lsb_full_seen), 32'd1);
        li = 0;
        for (int i = 0; i < log_tag.size(); i++) begin
            if (log_src[i] == 1'b1) begin
                check("sat_lsb_order", 32'(log_tag[i]), 32'(li + 9));
                li++;
            end
        end
        check("sat_lsb_count", 32'(li), 32'd7);
        check("sat_total", log_tag.size(), 32'd17);

        // Rollback with entries queued and a new result offered in the same cycle.
        for (int i = 0; i < 3; i++) begin
            alu_valid_in = 1; alu_result_in = 32'h500 + i; alu_new_pc_in = 0; alu_dest_tag_in = 4'(i + 1);
            lsb_valid_in = (i < 2); lsb_result_in = 32'h600 + i; lsb_dest_tag_in = 4'(i + 9);
            step();
        end
        lsb_valid_in = 0;
        alu_valid_in = 1; alu_result_in = 32'h666; alu_dest_tag_in = 4'd6;
        rollback_in = 1;
        step();
        idle_inputs();
        check("rb_valid", 32'(cdb_valid_out), 32'd0);
        check("rb_alu_rdy", 32'(alu_ready_out), 32'd1);
        check("rb_lsb_rdy", 32'(lsb_ready_out), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("rb_no_bcast", 32'(cdb_valid_out), 32'd0);
        end

        // Null tag: accepted by the handshake, never broadcast.
        alu_valid_in = 1; alu_result_in = 32'h55; alu_new_pc_in = 32'h200; alu_dest_tag_in = 4'd0;
        check("null_rdy", 32'(alu_ready_out), 32'd1);
        step();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            step();
            check("null_no_bcast", 32'(cdb_valid_out), 32'd0);
        end

        check_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
